// File: rtl/lh_digest_hex_serializer.sv
// Light-hash digest to ASCII hex byte stream: one holding register in front of a
// 64-bit shift register, most-significant nibble first, optional trailing newline.
module lh_digest_hex_serializer #(
  parameter bit UPPERCASE = 1'b0,
  parameter bit APPEND_NL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] digest_in,
  input  logic        digest_ready,
  output logic [7:0]  hex_char,
  output logic        hex_valid,
  input  logic        hex_ready,
  output logic        hex_last,
  output logic        busy,
  output logic        err_overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] NL   = 2'd2;

  logic [1:0]  state;
  logic [63:0] hold;
  logic        hold_full;
  logic [63:0] sr;
  logic [4:0]  cnt;

  logic accept;
  logic xfer;
  logic capture;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  assign accept  = hex_valid && hex_ready;
  assign xfer    = (state == IDLE) && hold_full;
  // A strobe may refill hold on the very edge that empties it into sr.
  assign capture = digest_ready && (!hold_full || xfer);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      hold_full    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (capture)          hold_full <= 1'b1;
      else if (xfer)        hold_full <= 1'b0;
      if (digest_ready && !capture) err_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (xfer) begin
            state <= SEND;
            cnt   <= 5'd0;
          end
        end
        SEND: begin
          if (accept) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd15) state <= APPEND_NL ? NL : IDLE;
          end
        end
        NL: begin
          if (accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the data registers carry no reset; their contents are only observed
  // once the control path has loaded them, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (capture) hold <= digest_in;
    if (xfer)                          sr <= hold;
    else if (state == SEND && accept)  sr <= {sr[59:0], 4'h0};
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    hex_char = 8'h00;
    case (state)
      SEND:    hex_char = to_ascii(sr[63:60]);
      NL:      hex_char = 8'h0A;
      default: hex_char = 8'h00;
    endcase
  end

  assign hex_valid = (state == SEND) || (state == NL);
  assign hex_last  = ((state == SEND) && (cnt == 5'd15) && !APPEND_NL) || (state == NL);
  assign busy      = hold_full || (state != IDLE);

endmodule
